// File: rtl/pcie_vc_injector.sv
// pcie_vc_injector: two-VC upstream word queue with round-robin issue and per-VC pause/continue flow control.
module pcie_vc_injector #(
  parameter int ADDR_WIDTH = 2,
  parameter int BUS_SIZE   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_SIZE-1:0]   in_data,
  input  logic                  in_vc,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  pause_VC0,
  input  logic                  continue_VC0,
  input  logic                  pause_VC1,
  input  logic                  continue_VC1,
  output logic [BUS_SIZE:0]     data_p,
  output logic                  valid_p,
  output logic [ADDR_WIDTH:0]   occ_vc0,
  output logic [ADDR_WIDTH:0]   occ_vc1
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL = DEPTH[ADDR_WIDTH:0];
  logic [1:0][DEPTH-1:0][BUS_SIZE-1:0] mem_q, mem_d;
  logic [1:0][ADDR_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [1:0][ADDR_WIDTH:0] occ_q, occ_d;
  logic [1:0] hold_q, hold_d, pause, cont, elig, push, pop;
  logic rr_last_q, rr_last_d, valid_p_q, valid_p_d, gnt, gvc;
  logic [BUS_SIZE:0] data_p_q, data_p_d;
  assign pause    = {pause_VC1, pause_VC0};
  assign cont     = {continue_VC1, continue_VC0};
  assign in_ready = !reset && (occ_q[in_vc] != FULL);
  assign data_p   = data_p_q;
  assign valid_p  = valid_p_q;
  assign occ_vc0  = occ_q[0];
  assign occ_vc1  = occ_q[1];
  always_comb begin
    // pause dominates continue; the new hold value gates issue in the same cycle
    hold_d    = pause | (hold_q & ~cont);
    elig      = ~hold_d & {occ_q[1] != '0, occ_q[0] != '0};
    gnt       = |elig;
    gvc       = &elig ? !rr_last_q : elig[1];
    pop       = gnt ? {gvc, !gvc} : 2'b00;
    push      = (in_valid && in_ready) ? {in_vc, !in_vc} : 2'b00;
    mem_d     = mem_q;
    if (push[0]) mem_d[0][wr_q[0]] = in_data;
    if (push[1]) mem_d[1][wr_q[1]] = in_data;
    wr_d[0]   = wr_q[0] + ADDR_WIDTH'(push[0]);
    wr_d[1]   = wr_q[1] + ADDR_WIDTH'(push[1]);
    rd_d[0]   = rd_q[0] + ADDR_WIDTH'(pop[0]);
    rd_d[1]   = rd_q[1] + ADDR_WIDTH'(pop[1]);
    occ_d[0]  = occ_q[0] + (ADDR_WIDTH+1)'(push[0]) - (ADDR_WIDTH+1)'(pop[0]);
    occ_d[1]  = occ_q[1] + (ADDR_WIDTH+1)'(push[1]) - (ADDR_WIDTH+1)'(pop[1]);
    rr_last_d = gnt ? gvc : rr_last_q;
    valid_p_d = gnt;
    data_p_d  = gnt ? {gvc, mem_q[gvc][rd_q[gvc]]} : data_p_q;
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      occ_q     <= '0;
      hold_q    <= '0;
      rr_last_q <= 1'b1;
      valid_p_q <= 1'b0;
      data_p_q  <= '0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      occ_q     <= occ_d;
      hold_q    <= hold_d;
      rr_last_q <= rr_last_d;
      valid_p_q <= valid_p_d;
      data_p_q  <= data_p_d;
    end
  end
endmodule

// File: tb/tb_pcie_vc_injector.sv
// tb_pcie_vc_injector: directed vector table, hand sequences and random traffic against a queue-based model.
module tb_pcie_vc_injector;
  logic clk = 1'b0;
  logic reset, in_vc, in_valid, in_ready, pause_VC0, continue_VC0, pause_VC1, continue_VC1, valid_p;
  logic [4:0] in_data;
  logic [5:0] data_p;
  logic [2:0] occ_vc0, occ_vc1;
  int tests = 0, fails = 0;

  pcie_vc_injector #(.ADDR_WIDTH(2), .BUS_SIZE(5)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_vc(in_vc), .in_valid(in_valid),
    .in_ready(in_ready), .pause_VC0(pause_VC0), .continue_VC0(continue_VC0),
    .pause_VC1(pause_VC1), .continue_VC1(continue_VC1), .data_p(data_p),
    .valid_p(valid_p), .occ_vc0(occ_vc0), .occ_vc1(occ_vc1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, vld, vc;
    logic [4:0] d;
    logic [1:0] p, k;
    logic       er, ev;
    logic [5:0] ed;
  } vec_t;
  vec_t tbl[20];

  logic [4:0] q0[$], q1[$];
  logic [1:0] m_hold;
  logic       m_rr, m_valid;
  logic [5:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, v, c, input logic [4:0] d, input logic [1:0] p, k);
    reset = r; in_valid = v; in_vc = c; in_data = d;
    pause_VC0 = p[0]; pause_VC1 = p[1]; continue_VC0 = k[0]; continue_VC1 = k[1];
  endtask

  // One clock through the DUT and the model together, checking everything visible.
  task automatic cyc(input logic r, v, c, input logic [4:0] d, input logic [1:0] p, k);
    logic rdy, h0, h1, e0, e1, g;
    int sz;
    drive(r, v, c, d, p, k);
    #1;
    sz  = c ? q1.size() : q0.size();
    rdy = !r && sz < 4;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    if (r) begin
      q0.delete(); q1.delete();
      m_hold = 2'b00; m_rr = 1'b1; m_valid = 1'b0; m_data = 6'h00;
    end else begin
      h0 = p[0] ? 1'b1 : (k[0] ? 1'b0 : m_hold[0]);
      h1 = p[1] ? 1'b1 : (k[1] ? 1'b0 : m_hold[1]);
      e0 = !h0 && q0.size() != 0;
      e1 = !h1 && q1.size() != 0;
      g  = (e0 && e1) ? !m_rr : e1;
      m_valid = e0 || e1;
      if (m_valid) begin
        m_data = g ? {1'b1, q1.pop_front()} : {1'b0, q0.pop_front()};
        m_rr   = g;
      end
      if (v && rdy) begin
        if (c) q1.push_back(d); else q0.push_back(d);
      end
      m_hold = {h1, h0};
    end
    @(posedge clk);
    #1;
    chk("valid_p", 32'(valid_p), 32'(m_valid));
    chk("data_p", 32'(data_p), 32'(m_data));
    chk("occ_vc0", 32'(occ_vc0), q0.size());
    chk("occ_vc1", 32'(occ_vc1), q1.size());
  endtask

  initial begin
    logic [4:0] fd[5];
    //            rst vld vc d      p      k      er ev ed
    tbl[0]  = '{1'b1,1'b1,1'b0,5'h1F,2'b00,2'b00,1'b0,1'b0,6'h00};
    tbl[1]  = '{1'b1,1'b1,1'b0,5'h1F,2'b00,2'b00,1'b0,1'b0,6'h00};
    tbl[2]  = '{1'b1,1'b1,1'b1,5'h1F,2'b00,2'b00,1'b0,1'b0,6'h00};
    tbl[3]  = '{1'b0,1'b0,1'b0,5'h00,2'b00,2'b00,1'b1,1'b0,6'h00};
    tbl[4]  = '{1'b0,1'b1,1'b0,5'h0A,2'b00,2'b00,1'b1,1'b0,6'h00};
    tbl[5]  = '{1'b0,1'b0,1'b0,5'h00,2'b00,2'b00,1'b1,1'b1,6'h0A};
    tbl[6]  = '{1'b0,1'b0,1'b0,5'h00,2'b00,2'b00,1'b1,1'b0,6'h0A};
    tbl[7]  = '{1'b1,1'b0,1'b0,5'h00,2'b00,2'b00,1'b0,1'b0,6'h00};
    tbl[8]  = '{1'b0,1'b1,1'b0,5'h01,2'b11,2'b00,1'b1,1'b0,6'h00};
    tbl[9]  = '{1'b0,1'b1,1'b0,5'h02,2'b11,2'b00,1'b1,1'b0,6'h00};
    tbl[10] = '{1'b0,1'b1,1'b1,5'h03,2'b11,2'b00,1'b1,1'b0,6'h00};
    tbl[11] = '{1'b0,1'b1,1'b1,5'h04,2'b11,2'b00,1'b1,1'b0,6'h00};
    tbl[12] = '{1'b0,1'b0,1'b0,5'h00,2'b00,2'b11,1'b1,1'b1,6'h01};
    tbl[13] = '{1'b0,1'b0,1'b0,5'h00,2'b00,2'b00,1'b1,1'b1,6'h23};
    tbl[14] = '{1'b0,1'b0,1'b0,5'h00,2'b00,2'b00,1'b1,1'b1,6'h02};
    tbl[15] = '{1'b0,1'b0,1'b0,5'h00,2'b00,2'b00,1'b1,1'b1,6'h24};
    tbl[16] = '{1'b0,1'b0,1'b0,5'h00,2'b00,2'b00,1'b1,1'b0,6'h24};
    tbl[17] = '{1'b0,1'b1,1'b0,5'h05,2'b01,2'b01,1'b1,1'b0,6'h24};
    tbl[18] = '{1'b0,1'b0,1'b0,5'h00,2'b00,2'b00,1'b1,1'b0,6'h24};
    tbl[19] = '{1'b0,1'b0,1'b0,5'h00,2'b00,2'b01,1'b1,1'b1,6'h05};
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].vc, tbl[i].d, tbl[i].p, tbl[i].k);
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].er));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(valid_p), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), 32'(data_p), 32'(tbl[i].ed));
      if (tbl[i].rst) begin
        chk($sformatf("tbl%0d_occ0", i), 32'(occ_vc0), 0);
        chk($sformatf("tbl%0d_occ1", i), 32'(occ_vc1), 0);
      end
    end

    // full VC1 queue under pause, fifth word dropped, then drained in order
    fd = '{5'h11, 5'h12, 5'h13, 5'h14, 5'h15};
    cyc(1, 0, 0, 0, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, fd[i], 2'b10, 2'b00);
    chk("full_occ1", 32'(occ_vc1), 4);
    drive(0, 1, 1, 5'h16, 2'b10, 2'b00);
    #1;
    chk("full_ready", 32'(in_ready), 0);
    cyc(0, 0, 1, 0, 2'b00, 2'b10);
    chk("drain0", 32'(data_p), 32'({1'b1, fd[0]}));
    for (int i = 1; i < 4; i++) begin
      cyc(0, 0, 0, 0, 2'b00, 2'b00);
      chk($sformatf("drain%0d", i), 32'({valid_p, data_p}), 32'({2'b11, fd[i]}));
    end
    cyc(0, 0, 0, 0, 2'b00, 2'b00);
    chk("drain_done", 32'(valid_p), 0);

    // pause cuts a VC0 stream with zero slip; continue resumes next cycle
    cyc(1, 0, 0, 0, 2'b00, 2'b00);
    cyc(0, 1, 0, 5'h07, 2'b00, 2'b00);
    cyc(0, 1, 0, 5'h08, 2'b00, 2'b00);
    cyc(0, 1, 0, 5'h09, 2'b00, 2'b00);
    cyc(0, 0, 0, 0, 2'b01, 2'b00);
    chk("pause_block", 32'(valid_p), 0);
    cyc(0, 0, 0, 0, 2'b00, 2'b00);
    chk("pause_hold", 32'(valid_p), 0);
    cyc(0, 0, 0, 0, 2'b00, 2'b01);
    chk("continue_go", 32'({valid_p, data_p}), 32'({1'b1, 6'h09}));
    cyc(0, 1, 0, 5'h0C, 2'b01, 2'b01);
    cyc(0, 0, 0, 0, 2'b00, 2'b00);
    chk("pause_and_cont", 32'(valid_p), 0);
    cyc(0, 0, 0, 0, 2'b00, 2'b01);

    // reset with words queued in both VCs discards them all
    for (int i = 0; i < 6; i++) cyc(0, 1, i[0], 5'(i + 16), 2'b11, 2'b00);
    chk("pre_reset_occ", 32'({occ_vc1, occ_vc0}), 32'({3'd3, 3'd3}));
    cyc(1, 0, 0, 0, 2'b00, 2'b00);
    chk("reset_occ", 32'({occ_vc1, occ_vc0}), 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 2'b00, 2'b11);
      chk("no_stale", 32'(valid_p), 0);
    end

    // random traffic against the model
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 79) == 0, 1'($urandom), 1'($urandom), 5'($urandom),
          {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0},
          {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
